signed_frame_accumulator: RTL
=============================

// Module: signed_frame_accumulator
// PURPOSE
//   Downstream consumer of the 8-bit two's-complement negation stage.
//   Accepts signed samples over a valid/ready handshake and accumulates
//   FRAME_LEN of them into a saturating signed sum. It presents each
//   frame sum, plus a saturation flag, on an output valid/ready handshake.
//   Used to aggregate negated/signed operands before the next arithmetic stage.
// PARAMETERS
//   DATA_W     8   input sample width, two's complement
//   ACC_W      12  accumulator/sum width, two's complement; must be >= DATA_W
//   FRAME_LEN  4   samples per frame; must be >= 1
//   CNT_W      $clog2(FRAME_LEN)+1 (localparam) width of count
// PORTS
//   clk        in   1       single clock; all state updates on rising edge
//   rst        in   1       synchronous, active-high reset
//   in_data    in   DATA_W  signed sample (two's complement)
//   in_valid   in   1       in_data is valid this cycle
//   in_ready   out  1       block accepts a sample this cycle
//   sum_out    out  ACC_W   signed frame sum, saturated
//   sum_valid  out  1       sum_out/sat hold a completed frame
//   sum_ready  in   1       downstream accepts sum_out this cycle
//   sat        out  1       saturation occurred at least once in reported frame
//   count      out  CNT_W   samples accepted so far in the current frame
// BEHAVIOUR
//   Reset (rst=1 at clk edge): state=ACCUM, acc=0, count=0, sum_out=0,
//     sum_valid=0, sat=0, internal sticky flag=0. Any partial frame is discarded.
//   States: ACCUM (collecting samples), HOLD (presenting sum).
//   in_ready = (state==ACCUM), combinational from state only. sum_valid = (state==HOLD).
//   Sample accept: in_valid && in_ready at a clk edge.
//     next = acc + sign_extend(in_data), computed at ACC_W+1 bits.
//     If next > 2^(ACC_W-1)-1, clamp to the max and set the sticky flag.
//       If next < -2^(ACC_W-1), clamp to the min and set the sticky flag.
//     Accumulation continues from the clamped value.
//   On accept with count < FRAME_LEN-1: acc<=clamped next; count<=count+1.
//   On accept with count == FRAME_LEN-1 (last sample):
//     sum_out<=clamped next; sat<=sticky|this-beat-saturation; acc<=0;
//     count<=0; sticky<=0; state<=HOLD.
//   Latency: sum_valid rises on the edge that accepts the last sample.
//     It is visible the cycle after that sample's handshake.
//   HOLD: in_ready=0; in_data/in_valid are ignored (no accept, no count change).
//     sum_out and sat are stable until the handshake.
//   Output handshake: sum_valid && sum_ready at an edge -> state<=ACCUM.
//     The next sample can be accepted the following cycle. sum_out/sat keep
//     their last values after the handshake.
//   in_valid gaps inside a frame: no effect on acc/count.
//   FRAME_LEN=1: every accepted sample produces a sum, with a HOLD after each.
//   rst has priority over every handshake in the same cycle.
// TESTING  (DATA_W=8, FRAME_LEN=4; ACC_W=12 unless noted)
//   1 Reset: rst high 2 cycles -> in_ready=1, sum_valid=0, sum_out=0, sat=0,
//     count=0.
//   2 Samples 1,5,127,0x80(-128) back-to-back, sum_ready=1 -> sum_out=12'h005,
//     sat=0. sum_valid is high for exactly 1 cycle, starting the cycle after
//     the 4th accept.
//   3 Backpressure: sum_ready=0 for 3 cycles while in_valid=1 with data 9 ->
//     in_ready=0, count stays 0, sum_out stable. Then sum_ready=1 -> ACCUM;
//     the next accept sets count=1.
//   4 ACC_W=9: 127,127,127,1 -> sum_out=9'h0FF (255), sat=1.
//     Next frame -128 x4 -> sum_out=9'h100 (-256), sat=1.
//     Next frame 1,1,1,1 -> sum 4, sat=0 (sticky flag cleared per frame).
//   5 Reset mid-frame: accept 50,50, assert rst 1 cycle, then 1,1,1,1 ->
//     sum_out=4, sat=0.
//   6 Gappy input: 3,-3,7,-1 with 1-2 idle cycles between valids -> sum_out=6;
//     count steps 0,1,2,3 then 0.

Source files
------------

// File: rtl/signed_frame_accumulator.sv
// Accumulates FRAME_LEN signed samples into a saturating signed sum.
// Each completed sum and its saturation flag are held until downstream takes them.
module signed_frame_accumulator #(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 12,
    parameter int FRAME_LEN = 4,
    localparam int CNT_W    = $clog2(FRAME_LEN) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              sat,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [ACC_W-1:0] acc;
    logic             sticky;
    logic [ACC_W:0]   sum_wide;
    logic             sat_now;
    logic [ACC_W-1:0] clamped;
    logic             accept;
    logic             last;

    assign accept = in_valid && in_ready;
    assign last   = (count == CNT_W'(FRAME_LEN - 1));

    // One guard bit is enough: overflow shows as the two top bits disagreeing.
    always_comb begin
        sum_wide = {acc[ACC_W-1], acc}
                 + {{(ACC_W + 1 - DATA_W){in_data[DATA_W-1]}}, in_data};
        sat_now  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        clamped  = sum_wide[ACC_W-1:0];
        if (sat_now) begin
            clamped = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (accept && last) state_next = HOLD;
            HOLD:    if (sum_ready)      state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state == ACCUM);
        sum_valid = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            count   <= '0;
            sticky  <= 1'b0;
            sum_out <= '0;
            sat     <= 1'b0;
        end else if (accept) begin
            if (last) begin
                sum_out <= clamped;
                sat     <= sticky | sat_now;
                acc     <= '0;
                count   <= '0;
                sticky  <= 1'b0;
            end else begin
                acc     <= clamped;
                count   <= count + 1'b1;
                sticky  <= sticky | sat_now;
            end
        end
    end

endmodule
